// File: rtl/universal_ff_bank_if.sv
// Signal bundle for universal_ff_bank: mode/operand inputs and bank state outputs.
// Carries no timing of its own; the bank registers every output.
// No flow control: the bank accepts a new operand set every cycle.
interface universal_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  // Control and operands, driven by the user of the bank
  logic             mode_wr;
  logic [1:0]       mode_in;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;

  // Bank state, driven by the bank
  logic [1:0]       mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] chg;
  logic             sr_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output mode_wr, mode_in, en, a, b, err_clr,
    input  mode, q, chg, sr_err, err_cnt
  );

  modport slave (
    input  mode_wr, mode_in, en, a, b, err_clr,
    output mode, q, chg, sr_err, err_cnt
  );

endinterface

// File: rtl/universal_ff_bank.sv
// WIDTH-bit D-storage bank emulating D/SR/JK/T flip-flops per a run-time mode.
// Latency: 1 cycle from operands (or mode write) to q, chg, sr_err and err_cnt.
// Backpressure: none; every cycle's inputs are consumed, nothing is ever stalled.
module universal_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  universal_ff_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_SR = 2'b01,
    MODE_JK = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Architectural state
  mode_e            mode_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] chg_r;
  logic             sr_err_r;
  logic [CNT_W-1:0] err_cnt_r;

  // Per-mode candidate next states, each computed from the current q
  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] jk_nxt;
  logic [WIDTH-1:0] t_nxt;

  // Selected next state and error bookkeeping
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] sr_bad_bits;
  logic             illegal_evt;
  logic [CNT_W-1:0] cnt_sat_inc;
  logic             sr_err_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;

  // Candidate next states for every flip-flop flavour, bit-parallel.
  // SR with S=R=1 falls through to hold so the state never goes unknown.
  always_comb begin
    d_nxt  = bus.a;
    sr_nxt = q_r;
    jk_nxt = q_r;
    t_nxt  = q_r ^ bus.a;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({bus.a[i], bus.b[i]})
        2'b00:   sr_nxt[i] = q_r[i];
        2'b01:   sr_nxt[i] = 1'b0;
        2'b10:   sr_nxt[i] = 1'b1;
        default: sr_nxt[i] = q_r[i];
      endcase
      unique case ({bus.a[i], bus.b[i]})
        2'b00:   jk_nxt[i] = q_r[i];
        2'b01:   jk_nxt[i] = 1'b0;
        2'b10:   jk_nxt[i] = 1'b1;
        default: jk_nxt[i] = ~q_r[i];
      endcase
    end
  end

  // Next-state select: a mode write clears the bank and outranks en.
  always_comb begin
    q_nxt = q_r;
    if (bus.mode_wr) begin
      q_nxt = '0;
    end else if (bus.en) begin
      unique case (mode_r)
        MODE_D:  q_nxt = d_nxt;
        MODE_SR: q_nxt = sr_nxt;
        MODE_JK: q_nxt = jk_nxt;
        MODE_T:  q_nxt = t_nxt;
        default: q_nxt = q_r;
      endcase
    end
  end

  // Illegal-input detection: one event per cycle no matter how many bits collide.
  always_comb begin
    sr_bad_bits = bus.a & bus.b;
    illegal_evt = (mode_r == MODE_SR) && bus.en && !bus.mode_wr && (|sr_bad_bits);
    cnt_sat_inc = (err_cnt_r == CNT_MAX) ? err_cnt_r : (err_cnt_r + CNT_ONE);
  end

  // Sticky flag and saturating counter; a fresh event beats a same-cycle clear.
  always_comb begin
    sr_err_nxt  = sr_err_r;
    err_cnt_nxt = err_cnt_r;
    if (illegal_evt) begin
      sr_err_nxt  = 1'b1;
      err_cnt_nxt = bus.err_clr ? CNT_ONE : cnt_sat_inc;
    end else if (bus.err_clr) begin
      sr_err_nxt  = 1'b0;
      err_cnt_nxt = '0;
    end
  end

  // Mode register: only a mode write changes the flip-flop flavour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r <= MODE_D;
    end else if (bus.mode_wr) begin
      mode_r <= mode_e'(bus.mode_in);
    end
  end

  // Storage bits plus the one-cycle change pulse derived from old vs new state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r   <= '0;
      chg_r <= '0;
    end else begin
      q_r   <= q_nxt;
      chg_r <= q_r ^ q_nxt;
    end
  end

  // Error reporting state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_err_r  <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      sr_err_r  <= sr_err_nxt;
      err_cnt_r <= err_cnt_nxt;
    end
  end

  assign bus.mode    = mode_r;
  assign bus.q       = q_r;
  assign bus.chg     = chg_r;
  assign bus.sr_err  = sr_err_r;
  assign bus.err_cnt = err_cnt_r;

endmodule
